// File: rtl/turn_signal_controller.sv
// turn_signal_controller: left/right/hazard sequencer for a 6-lamp rear cluster.
// Optional brake override lamp forcing is enabled by defining TURN_BRAKE_EN.
module turn_signal_controller #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       l,
    input  logic       r,
    input  logic       haz,
`ifdef TURN_BRAKE_EN
    input  logic       brake,
`endif
    output logic [3:0] y,
    output logic [5:0] led
);
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        L1   = 4'd1,
        L2   = 4'd2,
        L3   = 4'd3,
        R1   = 4'd4,
        R2   = 4'd5,
        R3   = 4'd6,
        HAZ  = 4'd7
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_pend_l;
    logic        r_pend_r;
    logic        r_pend_h;
    logic        w_step;
    logic        w_req_l;
    logic        w_req_r;
    logic        w_req_h;
    logic [5:0]  w_led;

    assign w_step  = r_cnt == 16'(TICK_DIV - 1);
    assign w_req_l = r_pend_l | l;
    assign w_req_r = r_pend_r | r;
    assign w_req_h = r_pend_h | haz;

    // Pending flags latch every request; a consuming transition below overrides the set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pend_l <= 1'b0;
            r_pend_r <= 1'b0;
            r_pend_h <= 1'b0;
        end else begin
            r_cnt    <= w_step ? '0 : r_cnt + 16'd1;
            r_pend_l <= w_req_l;
            r_pend_r <= w_req_r;
            r_pend_h <= w_req_h;
            if (r_state[3]) begin
                r_state <= IDLE;
            end else if (w_step) begin
                case (r_state)
                    IDLE: begin
                        if (w_req_h || (w_req_l && w_req_r)) begin
                            r_state  <= HAZ;
                            r_pend_l <= 1'b0;
                            r_pend_r <= 1'b0;
                            r_pend_h <= 1'b0;
                        end else if (w_req_l) begin
                            r_state  <= L1;
                            r_pend_l <= 1'b0;
                        end else if (w_req_r) begin
                            r_state  <= R1;
                            r_pend_r <= 1'b0;
                        end
                    end
                    L1, L2, R1, R2: begin
                        if (w_req_h) begin
                            r_state  <= HAZ;
                            r_pend_l <= 1'b0;
                            r_pend_r <= 1'b0;
                            r_pend_h <= 1'b0;
                        end else begin
                            r_state <= state_t'(r_state + 4'd1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (r_state)
            L1:      w_led = 6'b001000;
            L2:      w_led = 6'b011000;
            L3:      w_led = 6'b111000;
            R1:      w_led = 6'b000100;
            R2:      w_led = 6'b000110;
            R3:      w_led = 6'b000111;
            HAZ:     w_led = 6'b111111;
            default: w_led = 6'b000000;
        endcase
`ifdef TURN_BRAKE_EN
        // Brake lights every side that is not currently animating a turn.
        if (brake && !(r_state inside {L1, L2, L3})) w_led[5:3] = 3'b111;
        if (brake && !(r_state inside {R1, R2, R3})) w_led[2:0] = 3'b111;
`endif
    end

    assign y   = r_state;
    assign led = w_led;
endmodule

// File: tb/tb_turn_signal_controller.sv
// tb_turn_signal_controller: directed-vector bench for turn_signal_controller.
// Covers TICK_DIV=1 and TICK_DIV=3 instances, plus brake override when TURN_BRAKE_EN is defined.
module tb_turn_signal_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       l = 1'b0;
    logic       r = 1'b0;
    logic       haz = 1'b0;
    logic       brake = 1'b0;
    logic [3:0] y0, y3;
    logic [5:0] led0, led3;
    int         n_vec = 0;
    int         n_err = 0;

    localparam logic [5:0] D  = 6'b000000;
    localparam logic [5:0] A1 = 6'b001000;
    localparam logic [5:0] A2 = 6'b011000;
    localparam logic [5:0] A3 = 6'b111000;
    localparam logic [5:0] B1 = 6'b000100;
    localparam logic [5:0] B2 = 6'b000110;
    localparam logic [5:0] B3 = 6'b000111;
    localparam logic [5:0] H  = 6'b111111;

    always #5 clk = ~clk;

    turn_signal_controller #(.TICK_DIV(1)) u0 (
        .clk(clk), .reset(reset), .l(l), .r(r), .haz(haz),
`ifdef TURN_BRAKE_EN
        .brake(brake),
`endif
        .y(y0), .led(led0)
    );

    turn_signal_controller #(.TICK_DIV(3)) u3 (
        .clk(clk), .reset(reset), .l(l), .r(r), .haz(haz),
`ifdef TURN_BRAKE_EN
        .brake(brake),
`endif
        .y(y3), .led(led3)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic st0(input string tag, input logic [3:0] ey, input logic [5:0] el);
        chk({tag, ".y"}, 8'(y0), 8'(ey));
        chk({tag, ".led"}, 8'(led0), 8'(el));
    endtask

    task automatic st3(input string tag, input logic [3:0] ey, input logic [5:0] el);
        chk({tag, ".y"}, 8'(y3), 8'(ey));
        chk({tag, ".led"}, 8'(led3), 8'(el));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tick;
            st0("reset", 4'd0, D);
        end
        reset = 1'b0;
        tick; st0("idle0", 4'd0, D);
        tick; st0("idle1", 4'd0, D);

        l = 1'b1; tick; st0("lp.L1", 4'd1, A1);
        l = 1'b0; tick; st0("lp.L2", 4'd2, A2);
        tick; st0("lp.L3", 4'd3, A3);
        tick; st0("lp.idle", 4'd0, D);
        tick; st0("lp.hold", 4'd0, D);

        l = 1'b1; tick; st0("lr.L1", 4'd1, A1);
        l = 1'b0; tick; st0("lr.L2", 4'd2, A2);
        r = 1'b1; tick; st0("lr.L3", 4'd3, A3);
        r = 1'b0; tick; st0("lr.idle", 4'd0, D);
        tick; st0("lr.R1", 4'd4, B1);
        tick; st0("lr.R2", 4'd5, B2);
        tick; st0("lr.R3", 4'd6, B3);
        tick; st0("lr.idle2", 4'd0, D);
        tick; st0("lr.hold", 4'd0, D);

        l = 1'b1; r = 1'b1; tick; st0("both.haz", 4'd7, H);
        l = 1'b0; r = 1'b0; tick; st0("both.idle", 4'd0, D);
        tick; st0("both.hold", 4'd0, D);

        r = 1'b1; tick; st0("hz.R1", 4'd4, B1);
        r = 1'b0; haz = 1'b1; tick; st0("hz.pre", 4'd7, H);
        tick; st0("hz.dark", 4'd0, D);
        tick; st0("hz.on", 4'd7, H);
        tick; st0("hz.dark2", 4'd0, D);
        tick; st0("hz.on2", 4'd7, H);
        reset = 1'b1; tick; st0("hz.reset", 4'd0, D);
        haz = 1'b0; tick; st0("hz.reset2", 4'd0, D);
        reset = 1'b0; tick; st0("hz.after", 4'd0, D);

        l = 1'b1; tick; st0("held.L1", 4'd1, A1);
        tick; st0("held.L2", 4'd2, A2);
        tick; st0("held.L3", 4'd3, A3);
        tick; st0("held.idle", 4'd0, D);
        tick; st0("held.L1b", 4'd1, A1);
        l = 1'b0; tick; st0("held.L2b", 4'd2, A2);
        tick; st0("held.L3b", 4'd3, A3);
        tick; st0("held.idle2", 4'd0, D);
        tick; st0("held.hold", 4'd0, D);

        l = 1'b1; tick; st0("l3.L1", 4'd1, A1);
        l = 1'b0; tick; st0("l3.L2", 4'd2, A2);
        tick; st0("l3.L3", 4'd3, A3);
        haz = 1'b1; tick; st0("l3.nopre", 4'd0, D);
        haz = 1'b0; tick; st0("l3.pendh", 4'd7, H);
        tick; st0("l3.idle", 4'd0, D);

        reset = 1'b1; tick; st3("d3.reset", 4'd0, D);
        reset = 1'b0; tick; st3("d3.c1", 4'd0, D);
        l = 1'b1; tick; st3("d3.c2", 4'd0, D);
        l = 1'b0; tick; st3("d3.L1a", 4'd1, A1);
        tick; st3("d3.L1b", 4'd1, A1);
        tick; st3("d3.L1c", 4'd1, A1);
        for (int i = 0; i < 3; i++) begin tick; st3("d3.L2", 4'd2, A2); end
        for (int i = 0; i < 3; i++) begin tick; st3("d3.L3", 4'd3, A3); end
        for (int i = 0; i < 4; i++) begin tick; st3("d3.idle", 4'd0, D); end

`ifdef TURN_BRAKE_EN
        reset = 1'b1; tick;
        reset = 1'b0; tick; st0("br.idle", 4'd0, D);
        l = 1'b1; tick; st0("br.L1", 4'd1, A1);
        l = 1'b0; tick; st0("br.L2", 4'd2, A2);
        brake = 1'b1; #1; st0("br.L2on", 4'd2, 6'b011111);
        brake = 1'b0; tick; st0("br.L3", 4'd3, A3);
        tick; st0("br.idle2", 4'd0, D);
        brake = 1'b1; #1; st0("br.idleon", 4'd0, H);
        brake = 1'b0; #1; st0("br.off", 4'd0, D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
